// File: rtl/trp_sched_pkg.sv
// Shared types for the transpose job scheduler: job descriptor, FSM state
// encoding and the mode codes understood by the transpose engine.
package trp_sched_pkg;

  localparam int AW   = 16;
  localparam int DIMD = 6;

  localparam logic [1:0] BIT8_MODE  = 2'b01;
  localparam logic [1:0] BIT32_MODE = 2'b10;

  typedef struct packed {
    logic [1:0]               mode;
    logic                     repack_en;
    logic [AW-1:0]            areq_num;
    logic [AW-1:0]            packed_size;
    logic [AW-1:0]            packed_stride;
    logic [AW-1:0]            unpacked_size;
    logic [AW-1:0]            unpacked_stride;
    logic [AW-1:0]            raddr_base;
    logic [AW-1:0]            waddr_base;
    logic [DIMD-1:0][AW-1:0]  size;
    logic [DIMD-1:0][AW-1:0]  stride;
    logic [AW-1:0]            exp_wcnt;
    logic [7:0]               tag;
  } trp_desc_t;

  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_ARB   = 6'b000010,
    ST_LOAD  = 6'b000100,
    ST_START = 6'b001000,
    ST_RUN   = 6'b010000,
    ST_DONE  = 6'b100000
  } sched_state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr_i
// wins; the pointer itself is owned by the parent.
module rr_arbiter
  import trp_sched_pkg::*;
#(
  parameter int  NREQ = 2,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW:0]   c_sum;
  logic [IW-1:0] c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c_sum = '0;
    c     = '0;
    for (int k = 0; k < NREQ; k++) begin
      c_sum = {1'b0, ptr_i} + (IW+1)'(k);
      c     = (c_sum >= (IW+1)'(NREQ)) ? IW'(c_sum - (IW+1)'(NREQ)) : IW'(c_sum);
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = c;
      end
    end
  end

endmodule

// File: rtl/transpose_sched.sv
// Job scheduler in front of the transpose engine: arbitrates descriptors,
// programs the engine, counts write beats and recovers a hung engine.
//
// state    | meaning
// ST_IDLE  | no job, waiting for any req_vld
// ST_ARB   | grant pulse, descriptor latched into cfg regs
// ST_LOAD  | cfg settle cycle; empty jobs skip straight to ST_DONE
// ST_START | init_pulse to the engine, watchdog cleared
// ST_RUN   | counting write beats, watchdog running
// ST_DONE  | completion pulse with id/tag/err
module transpose_sched
  import trp_sched_pkg::*;
#(
  parameter int  NREQ = 2,
  parameter int  TOW  = 16,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_vld,
  output logic [NREQ-1:0]       req_rdy,
  input  trp_desc_t [NREQ-1:0]  req_desc,
  output logic [1:0]            cfg_mode,
  output logic                  cfg_repack_en,
  output trp_desc_t             cfg_desc,
  output logic                  init_pulse,
  input  logic                  eng_wdata_vld,
  output logic                  busy,
  output logic                  done_vld,
  output logic [IW-1:0]         done_id,
  output logic [7:0]            done_tag,
  output logic                  done_err
);

  localparam logic [TOW-1:0] WD_MAX  = '1;
  localparam logic [TOW-1:0] WD_LAST = {{(TOW-1){1'b1}}, 1'b0};

  sched_state_t    state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   id_q, id_d;
  trp_desc_t       desc_q, desc_d;
  logic [AW-1:0]   wcnt_q, wcnt_d;
  logic [TOW-1:0]  wd_q, wd_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            final_beat;
  logic            wd_expire;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i (req_vld),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // A beat in the saturation cycle suppresses the timeout.
  assign final_beat = eng_wdata_vld && (wcnt_q == desc_q.exp_wcnt - AW'(1));
  assign wd_expire  = !eng_wdata_vld && (wd_q == WD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      desc_q  <= '0;
      wcnt_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      desc_q  <= desc_d;
      wcnt_q  <= wcnt_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    desc_d  = desc_q;
    wcnt_d  = wcnt_q;
    wd_d    = wd_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_vld) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (arb_any) begin
          desc_d  = req_desc[arb_idx];
          id_d    = arb_idx;
          wcnt_d  = '0;
          err_d   = 1'b0;
          ptr_d   = (arb_idx == IW'(NREQ-1)) ? '0 : arb_idx + IW'(1);
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (desc_q.exp_wcnt == '0) begin
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        wd_d    = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (eng_wdata_vld) begin
          wcnt_d = wcnt_q + AW'(1);
          wd_d   = '0;
          if (final_beat) begin
            err_d   = 1'b0;
            state_d = ST_DONE;
          end
        end else if (wd_expire) begin
          wd_d    = WD_MAX;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (wd_q != WD_MAX) begin
          wd_d = wd_q + TOW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req_rdy    = (state_q == ST_ARB) ? arb_gnt : '0;
  assign init_pulse = (state_q == ST_START);
  assign busy       = (state_q != ST_IDLE);
  assign done_vld   = (state_q == ST_DONE);
  assign done_id    = done_vld ? id_q : '0;
  assign done_tag   = done_vld ? desc_q.tag : 8'h00;
  assign done_err   = done_vld && err_q;

  // Repack is dropped in a timeout completion to quiesce the engine FIFO path.
  assign cfg_desc      = desc_q;
  assign cfg_mode      = desc_q.mode;
  assign cfg_repack_en = desc_q.repack_en && !(done_vld && err_q);

endmodule

// File: tb/tb_transpose_sched.sv
// Self-checking bench for transpose_sched: timeline model of job grant,
// init, completion and watchdog checked every cycle, plus directed checks.
module tb_transpose_sched;
  import trp_sched_pkg::*;

  localparam int NREQ = 2;
  localparam int TOW  = 4;
  localparam int WDL  = 15;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        req_vld;
  logic [1:0]        req_rdy;
  trp_desc_t [1:0]   req_desc;
  logic [1:0]        cfg_mode;
  logic              cfg_repack_en;
  trp_desc_t         cfg_desc;
  logic              init_pulse;
  logic              eng_wdata_vld;
  logic              busy;
  logic              done_vld;
  logic [0:0]        done_id;
  logic [7:0]        done_tag;
  logic              done_err;

  always #5 clk = ~clk;

  transpose_sched #(.NREQ(NREQ), .TOW(TOW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_vld       (req_vld),
    .req_rdy       (req_rdy),
    .req_desc      (req_desc),
    .cfg_mode      (cfg_mode),
    .cfg_repack_en (cfg_repack_en),
    .cfg_desc      (cfg_desc),
    .init_pulse    (init_pulse),
    .eng_wdata_vld (eng_wdata_vld),
    .busy          (busy),
    .done_vld      (done_vld),
    .done_id       (done_id),
    .done_tag      (done_tag),
    .done_err      (done_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int tcyc  = 0;

  always @(posedge clk) tcyc <= tcyc + 1;

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, tcyc);
    end
  endtask

  // Timeline model: a job granted at cycle g pulses init at g+2 (unless empty),
  // counts beats from g+3, completes one cycle after the last beat, after 15
  // silent cycles (timeout), or at g+2 for an empty job.
  bit        m_act = 0, m_pend = 0, m_err = 0;
  int        m_g, m_id, m_beats, m_last, m_done;
  int        m_ptr = 0;
  trp_desc_t m_jd, m_cfg;

  int        gnt_log[$];
  int        obs_rdy_c = -100, obs_init_c = -100, obs_done_c = -100, obs_beat_c = -100;
  int        init_cnt = 0, done_cnt = 0, obs_done_id = -1;
  logic      obs_done_err, obs_done_rep;
  logic [7:0] obs_done_tag;

  always @(negedge clk) begin
    logic [1:0] e_rdy;
    bit         e_init, e_done;
    if (!reset_n) begin
      m_act  = 0;
      m_pend = 0;
      m_ptr  = 0;
      m_cfg  = '0;
      chk("rst_busy", busy, 1'b0);
      chk("rst_req_rdy", req_rdy, 2'b00);
      chk("rst_init", init_pulse, 1'b0);
      chk("rst_done", done_vld, 1'b0);
      chk("rst_cfg_desc", cfg_desc, '0);
      chk("rst_repack", cfg_repack_en, 1'b0);
    end else begin
      if (m_pend) begin
        m_pend = 0;
        for (int k = 0; k < NREQ; k++)
          if (!m_act && req_vld[(m_ptr + k) % NREQ]) begin
            m_act = 1;
            m_id  = (m_ptr + k) % NREQ;
          end
        if (m_act) begin
          m_g     = tcyc;
          m_jd    = req_desc[m_id];
          m_beats = 0;
          m_last  = tcyc + 2;
          m_done  = (m_jd.exp_wcnt == 0) ? tcyc + 2 : -1;
          m_err   = 0;
          m_ptr   = (m_id + 1) % NREQ;
        end
      end
      e_rdy  = (m_act && tcyc == m_g) ? 2'(1 << m_id) : 2'b00;
      e_init = m_act && tcyc == m_g + 2 && m_jd.exp_wcnt != 0;
      e_done = m_act && tcyc == m_done;
      chk("req_rdy", req_rdy, e_rdy);
      chk("init_pulse", init_pulse, e_init);
      chk("busy", busy, m_act);
      chk("done_vld", done_vld, e_done);
      chk("done_id", done_id, e_done ? m_id : 0);
      chk("done_tag", done_tag, e_done ? m_jd.tag : 8'h00);
      chk("done_err", done_err, e_done && m_err);
      chk("cfg_desc", cfg_desc, m_cfg);
      chk("cfg_mode", cfg_mode, m_cfg.mode);
      chk("cfg_repack_en", cfg_repack_en, m_cfg.repack_en && !(e_done && m_err));
      if (m_act && tcyc == m_g) m_cfg = m_jd;
      if (m_act && m_done < 0 && tcyc >= m_g + 3) begin
        if (eng_wdata_vld) begin
          m_beats++;
          m_last = tcyc;
          if (m_beats == int'(m_jd.exp_wcnt)) m_done = tcyc + 1;
        end else if (tcyc - m_last == WDL) begin
          m_done = tcyc + 1;
          m_err  = 1;
        end
      end
      if (m_act && tcyc == m_done) m_act = 0;
      else if (!m_act && |req_vld) m_pend = 1;
    end
    if (|req_rdy) begin
      obs_rdy_c = tcyc;
      gnt_log.push_back(req_rdy[1] ? 1 : 0);
    end
    if (init_pulse) begin
      obs_init_c = tcyc;
      init_cnt++;
    end
    if (eng_wdata_vld) obs_beat_c = tcyc;
    if (done_vld) begin
      obs_done_c   = tcyc;
      done_cnt++;
      obs_done_err = done_err;
      obs_done_tag = done_tag;
      obs_done_id  = int'(done_id);
      obs_done_rep = cfg_repack_en;
    end
  end

  trp_desc_t q0[$], q1[$];
  bit        saw_init, saw_done;

  function automatic trp_desc_t mk(input int expn, input logic [7:0] tag,
                                   input logic rep, input logic [1:0] mode);
    trp_desc_t d;
    d = '0;
    d.mode            = mode;
    d.repack_en       = rep;
    d.areq_num        = 16'(expn * 3 + 1);
    d.packed_size     = 16'(tag * 2);
    d.packed_stride   = 16'h0040;
    d.unpacked_size   = 16'(tag + 7);
    d.unpacked_stride = 16'h0100;
    d.raddr_base      = {tag, 8'h10};
    d.waddr_base      = {8'h20, tag};
    for (int k = 0; k < DIMD; k++) begin
      d.size[k]   = 16'(tag + k);
      d.stride[k] = 16'(k * 64 + tag);
    end
    d.exp_wcnt = 16'(expn);
    d.tag      = tag;
    return d;
  endfunction

  task automatic present();
    req_vld[0] = (q0.size() != 0);
    req_vld[1] = (q1.size() != 0);
    if (q0.size() != 0) req_desc[0] = q0[0]; else req_desc[0] = '0;
    if (q1.size() != 0) req_desc[1] = q1[0]; else req_desc[1] = '0;
  endtask

  task automatic tick();
    logic [1:0] hs;
    @(negedge clk);
    hs       = req_vld & req_rdy;
    saw_init = init_pulse;
    saw_done = done_vld;
    @(posedge clk);
    #1;
    if (hs[0]) void'(q0.pop_front());
    if (hs[1]) void'(q1.pop_front());
    present();
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    saw_init = 0;
    while (!saw_init && n < 40) begin
      tick();
      n++;
    end
    n_cmp++;
    if (!saw_init) begin
      n_err++;
      $display("FAIL %s: init_pulse not seen within %0d cycles", nm, n);
    end
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    saw_done = 0;
    while (!saw_done && n < 60) begin
      tick();
      n++;
    end
    n_cmp++;
    if (!saw_done) begin
      n_err++;
      $display("FAIL %s: done_vld not seen within %0d cycles", nm, n);
    end
  endtask

  task automatic beats(input int n);
    eng_wdata_vld = 1'b1;
    repeat (n) tick();
    eng_wdata_vld = 1'b0;
  endtask

  initial begin
    trp_desc_t d;
    int ic, dc, gl, gv;
    req_vld       = '0;
    req_desc      = '0;
    eng_wdata_vld = 1'b0;
    reset_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // single job on requester 0
    q0.push_back(mk(4, 8'h5A, 1'b1, BIT8_MODE));
    present();
    wait_init("t1_init");
    beats(4);
    wait_done("t1_done");
    chk("t1_init_latency", obs_init_c - obs_rdy_c, 2);
    chk("t1_done_latency", obs_done_c - obs_beat_c, 1);
    chk("t1_id", obs_done_id, 0);
    chk("t1_tag", obs_done_tag, 8'h5A);
    chk("t1_err", obs_done_err, 1'b0);
    chk("t1_busy_after", busy, 1'b0);

    // stray beat while idle, then an empty job on requester 1
    eng_wdata_vld = 1'b1;
    tick();
    eng_wdata_vld = 1'b0;
    ic = init_cnt;
    q1.push_back(mk(0, 8'hC3, 1'b1, BIT32_MODE));
    present();
    wait_done("t3_done");
    chk("t3_err", obs_done_err, 1'b0);
    chk("t3_id", obs_done_id, 1);
    chk("t3_tag", obs_done_tag, 8'hC3);
    chk("t3_no_init", init_cnt, ic);
    chk("t3_done_latency", obs_done_c - obs_rdy_c, 2);

    // both requesters continuously valid, three jobs each
    gl = gnt_log.size();
    for (int k = 0; k < 3; k++) begin
      q0.push_back(mk(2 + k, 8'(8'h10 + k), 1'((k % 2) == 1), BIT8_MODE));
      q1.push_back(mk(3, 8'(8'h20 + k), 1'b1, BIT32_MODE));
    end
    present();
    for (int j = 0; j < 6; j++) begin
      wait_init("t2_init");
      beats(int'(cfg_desc.exp_wcnt));
      wait_done("t2_done");
    end
    for (int j = 0; j < 6; j++) begin
      gv = (gnt_log.size() > gl + j) ? gnt_log[gl + j] : -1;
      chk($sformatf("t2_grant%0d", j), gv, j % 2);
    end

    // watchdog timeout after one of eight beats
    q0.push_back(mk(8, 8'h77, 1'b1, BIT8_MODE));
    present();
    wait_init("t4_init");
    beats(1);
    wait_done("t4_done");
    chk("t4_err", obs_done_err, 1'b1);
    chk("t4_gap", obs_done_c - obs_beat_c, 16);
    chk("t4_repack_in_done", obs_done_rep, 1'b0);
    chk("t4_tag", obs_done_tag, 8'h77);

    // beats landing exactly on watchdog saturation win over the timeout
    q1.push_back(mk(3, 8'h99, 1'b1, BIT32_MODE));
    present();
    wait_init("t5_init");
    beats(1);
    repeat (14) tick();
    beats(1);
    repeat (14) tick();
    beats(1);
    wait_done("t5_done");
    chk("t5_err", obs_done_err, 1'b0);
    chk("t5_done_latency", obs_done_c - obs_beat_c, 1);
    chk("t5_repack_in_done", obs_done_rep, 1'b1);

    // reset in the middle of a running job
    dc = done_cnt;
    d  = mk(6, 8'hE1, 1'b1, BIT8_MODE);
    q0.push_back(d);
    present();
    wait_init("t6_init");
    beats(2);
    reset_n = 1'b0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_cfg_desc", cfg_desc, '0);
    chk("t6_cfg_mode", cfg_mode, 2'b00);
    chk("t6_repack", cfg_repack_en, 1'b0);
    chk("t6_done", done_vld, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    chk("t6_no_done_for_aborted", done_cnt, dc);
    q0.push_back(d);
    present();
    wait_init("t6_reinit");
    beats(6);
    wait_done("t6_redone");
    chk("t6_done_count", done_cnt - dc, 1);
    chk("t6_tag", obs_done_tag, 8'hE1);
    chk("t6_err", obs_done_err, 1'b0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "time limit");
  end

endmodule
